// File: rtl/risc_prog_loader.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : risc_prog_loader                                             |
// | Description : Streams instruction words into instruction memory from       |
// |               address 0, stops at the HLT opcode, then pulses the core-init |
// |               strobe and releases the core. Optional checksum stage is     |
// |               enabled with `define RISC_PROG_LOADER_CHECKSUM_EN.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module risc_prog_loader #(
    parameter int         ADDR_W     = 10,
    parameter int         MAX_WORDS  = 1024,
    parameter logic [5:0] HLT_OPCODE = 6'h3f
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [31:0]       in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_init,
    output logic              cpu_run,
    output logic              done,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_CHK  = 3'd2,
        S_INIT = 3'd3,
        S_RUN  = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    localparam logic [ADDR_W:0] c_last_idx = (ADDR_W+1)'(MAX_WORDS - 1);
    localparam logic [1:0]      c_err_ovf  = 2'b01;
    localparam logic [1:0]      c_err_sum  = 2'b10;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_mem_we;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [31:0]        r_mem_wdata;
    logic               r_cpu_init;
    logic               r_cpu_run;
    logic               r_done;
    logic [1:0]         r_err_code;
    logic [1:0]         w_err_nxt;
    logic [ADDR_W:0]    r_word_count;
    logic [ADDR_W:0]    w_cnt_nxt;
    logic               w_wr;
    logic               w_accept;
    logic               w_is_hlt;

`ifdef RISC_PROG_LOADER_CHECKSUM_EN
    logic [31:0]        r_xsum;
    logic [31:0]        w_xsum_nxt;
    assign in_ready = (r_state == S_LOAD) || (r_state == S_CHK);
`else
    assign in_ready = (r_state == S_LOAD);
`endif

    assign w_accept = in_valid & in_ready;
    assign w_is_hlt = (in_data[31:26] == HLT_OPCODE);

    always_comb begin
        w_state_nxt = r_state;
        w_wr        = 1'b0;
        w_cnt_nxt   = r_word_count;
        w_err_nxt   = r_err_code;
`ifdef RISC_PROG_LOADER_CHECKSUM_EN
        w_xsum_nxt  = r_xsum;
`endif
        case (r_state)
            S_IDLE, S_RUN, S_ERR: begin
                if (start) begin
                    w_state_nxt = S_LOAD;
                    w_cnt_nxt   = '0;
                    w_err_nxt   = 2'b00;
`ifdef RISC_PROG_LOADER_CHECKSUM_EN
                    w_xsum_nxt  = '0;
`endif
                end
            end
            S_LOAD: begin
                if (w_accept) begin
                    w_wr      = 1'b1;
                    w_cnt_nxt = r_word_count + 1'b1;
`ifdef RISC_PROG_LOADER_CHECKSUM_EN
                    w_xsum_nxt = r_xsum ^ in_data;
                    if (w_is_hlt) begin
                        w_state_nxt = S_CHK;
                    end else if (r_word_count == c_last_idx) begin
`else
                    if (w_is_hlt) begin
                        w_state_nxt = S_INIT;
                    end else if (r_word_count == c_last_idx) begin
`endif
                        w_state_nxt = S_ERR;
                        w_err_nxt   = c_err_ovf;
                    end
                end
            end
`ifdef RISC_PROG_LOADER_CHECKSUM_EN
            // The checksum word is compared only; it never reaches memory.
            S_CHK: begin
                if (w_accept) begin
                    if (in_data == r_xsum) begin
                        w_state_nxt = S_INIT;
                    end else begin
                        w_state_nxt = S_ERR;
                        w_err_nxt   = c_err_sum;
                    end
                end
            end
`endif
            S_INIT:  w_state_nxt = S_RUN;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered, which yields the init pulse two edges and the
    // run level three edges after the final accept.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_cpu_init   <= 1'b0;
            r_cpu_run    <= 1'b0;
            r_done       <= 1'b0;
            r_err_code   <= 2'b00;
            r_word_count <= '0;
`ifdef RISC_PROG_LOADER_CHECKSUM_EN
            r_xsum       <= '0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_mem_we     <= w_wr;
            if (w_wr) begin
                r_mem_addr  <= r_word_count[ADDR_W-1:0];
                r_mem_wdata <= in_data;
            end
            r_cpu_init   <= (r_state == S_INIT);
            r_cpu_run    <= (r_state == S_RUN) && !start;
            r_done       <= (r_state == S_RUN) && !start;
            r_err_code   <= w_err_nxt;
            r_word_count <= w_cnt_nxt;
`ifdef RISC_PROG_LOADER_CHECKSUM_EN
            r_xsum       <= w_xsum_nxt;
`endif
        end
    end

    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign cpu_init   = r_cpu_init;
    assign cpu_run    = r_cpu_run;
    assign done       = r_done;
    assign err_code   = r_err_code;
    assign word_count = r_word_count;

endmodule
`default_nettype wire
